// File: rtl/mcycle_pkg.sv
// ----------------------------------------------------------------------------
// mcycle_pkg
// Shared constants, the MCycleOp bit positions, the FSM state encoding and a
// small helper for the multi-cycle multiply/divide unit.
//
// Related configuration macro: MCYCLE_DIV_EN (used by mcycle_unit and
// mcycle_divstep; this package is the same in both builds).
// ----------------------------------------------------------------------------
package mcycle_pkg;

    // Datapath width and the number of radix-2 iterations per operation.
    localparam int unsigned DataWidth  = 32;
    localparam int unsigned NumIter    = 32;
    localparam int unsigned CountWidth = $clog2(NumIter);

    localparam logic [CountWidth-1:0] LastCount = CountWidth'(NumIter - 1);

    // MCycleOp bit positions: bit0 1 = divide, bit1 1 = unsigned.
    localparam int unsigned OpDivBit = 0;
    localparam int unsigned OpUnsBit = 1;

    typedef enum logic [1:0] {
        StIdle      = 2'd0,
        StComputing = 2'd1,
        StDone      = 2'd2
    } state_e;

    // Absolute value of a two's-complement word when the operation is signed;
    // the raw word otherwise. 0x80000000 maps to itself, which is the correct
    // unsigned magnitude.
    function automatic logic [DataWidth-1:0] magnitude(input logic [DataWidth-1:0] v,
                                                       input logic                 is_signed);
        return (is_signed && v[DataWidth-1]) ? -v : v;
    endfunction

endpackage

// File: rtl/mcycle_divstep.sv
// ----------------------------------------------------------------------------
// mcycle_divstep
// One combinational restoring-division step: shifts the next dividend bit
// (MSB of quo_i) into the partial remainder, trial-subtracts the divisor and
// shifts the resulting quotient bit into the LSB of the quotient.
//
// Ports:
//   rem_i     partial remainder before the step (always < divisor_i)
//   quo_i     remaining dividend bits / quotient bits so far
//   divisor_i divisor magnitude
//   rem_o     partial remainder after the step
//   quo_o     shifted quotient with the new bit in the LSB
//
// Configuration: the module only exists when MCYCLE_DIV_EN is defined, so the
// multiply-only build carries no divide logic at all.
// ----------------------------------------------------------------------------
`ifdef MCYCLE_DIV_EN
module mcycle_divstep
    import mcycle_pkg::*;
(
    input  logic [DataWidth-1:0] rem_i,
    input  logic [DataWidth-1:0] quo_i,
    input  logic [DataWidth-1:0] divisor_i,
    output logic [DataWidth-1:0] rem_o,
    output logic [DataWidth-1:0] quo_o
);

    logic [DataWidth:0] shifted;
    logic [DataWidth:0] diff;

    always_comb begin
        shifted = {rem_i, quo_i[DataWidth-1]};
        diff    = shifted - {1'b0, divisor_i};
        // rem_i < divisor_i keeps a non-negative difference below 2^DataWidth,
        // so the top bit of diff is a pure borrow flag.
        if (diff[DataWidth]) begin
            rem_o = shifted[DataWidth-1:0];
            quo_o = {quo_i[DataWidth-2:0], 1'b0};
        end else begin
            rem_o = diff[DataWidth-1:0];
            quo_o = {quo_i[DataWidth-2:0], 1'b1};
        end
    end

endmodule
`endif

// File: rtl/mcycle_unit.sv
// ----------------------------------------------------------------------------
// mcycle_unit
// Iterative 32x32 multiply / divide unit with an IDLE -> COMPUTING -> DONE FSM.
// One radix-2 step per cycle (shift-add multiply or restoring divide) on
// operand magnitudes, with a sign fix-up applied as the result is registered.
// Start seen in cycle 0 keeps Busy high in cycles 0-32; results appear in
// cycle 33 (DONE) and hold until the next completion or reset.
//
// Ports:
//   CLK       clock, all state on its rising edge
//   RESET     synchronous active-high reset, highest priority
//   Start     operation request (sampled in IDLE only)
//   MCycleOp  bit0 1 = divide / 0 = multiply, bit1 1 = unsigned / 0 = signed
//   Operand1  multiplicand or dividend
//   Operand2  multiplier or divisor
//   Result1   product low word or quotient
//   Result2   product high word or remainder
//   Busy      combinational stall request
//
// Configuration: MCYCLE_DIV_EN compiles in the divide datapath. Without it a
// divide request goes straight to DONE with both results zero.
// ----------------------------------------------------------------------------
module mcycle_unit
    import mcycle_pkg::*;
(
    input  logic                 CLK,
    input  logic                 RESET,
    input  logic                 Start,
    input  logic [1:0]           MCycleOp,
    input  logic [DataWidth-1:0] Operand1,
    input  logic [DataWidth-1:0] Operand2,
    output logic [DataWidth-1:0] Result1,
    output logic [DataWidth-1:0] Result2,
    output logic                 Busy
);

    localparam int unsigned AccWidth = 2 * DataWidth;

    state_e                state_q, state_d;
    logic [CountWidth-1:0] count_q, count_d;
    // Multiply: {partial product high, remaining multiplier bits}.
    // Divide:   {partial remainder, remaining dividend / quotient bits}.
    logic [AccWidth-1:0]   acc_q,   acc_d;
    logic [DataWidth-1:0]  mag2_q,  mag2_d;   // |Operand2|: multiplicand or divisor
    logic                  neg_q,   neg_d;    // negate product / quotient at the end
    logic [DataWidth-1:0]  res1_q,  res1_d;
    logic [DataWidth-1:0]  res2_q,  res2_d;

    logic                  is_signed;
    logic                  sign1;
    logic                  sign2;

    logic [DataWidth:0]    mul_sum;
    logic [AccWidth-1:0]   step_acc;
    logic [AccWidth-1:0]   prod;
    logic [DataWidth-1:0]  fin1;
    logic [DataWidth-1:0]  fin2;

    assign is_signed = ~MCycleOp[OpUnsBit];
    assign sign1     = is_signed & Operand1[DataWidth-1];
    assign sign2     = is_signed & Operand2[DataWidth-1];

`ifdef MCYCLE_DIV_EN
    logic                  is_div_q,  is_div_d;
    logic                  neg_rem_q, neg_rem_d;  // remainder follows dividend sign
    logic [DataWidth-1:0]  op1_q,     op1_d;      // raw dividend for divide-by-zero
    logic [DataWidth-1:0]  div_rem;
    logic [DataWidth-1:0]  div_quo;

    mcycle_divstep u_divstep (
        .rem_i     (acc_q[AccWidth-1:DataWidth]),
        .quo_i     (acc_q[DataWidth-1:0]),
        .divisor_i (mag2_q),
        .rem_o     (div_rem),
        .quo_o     (div_quo)
    );
`endif

    // Shift-add: add the multiplicand to the high half when the current
    // multiplier bit is set, then shift the 65-bit sum right by one.
    assign mul_sum = {1'b0, acc_q[AccWidth-1:DataWidth]} + (acc_q[0] ? {1'b0, mag2_q} : '0);

    always_comb begin
        step_acc = {mul_sum, acc_q[DataWidth-1:1]};
`ifdef MCYCLE_DIV_EN
        if (is_div_q) begin
            step_acc = {div_rem, div_quo};
        end
`endif
    end

    // Sign-corrected result of the final step, registered on entering DONE.
    always_comb begin
        prod = neg_q ? -step_acc : step_acc;
        fin1 = prod[DataWidth-1:0];
        fin2 = prod[AccWidth-1:DataWidth];
`ifdef MCYCLE_DIV_EN
        if (is_div_q) begin
            if (mag2_q == '0) begin
                fin1 = '1;
                fin2 = op1_q;
            end else begin
                fin1 = neg_q ? -step_acc[DataWidth-1:0] : step_acc[DataWidth-1:0];
                fin2 = neg_rem_q ? -step_acc[AccWidth-1:DataWidth]
                                 : step_acc[AccWidth-1:DataWidth];
            end
        end
`endif
    end

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        acc_d   = acc_q;
        mag2_d  = mag2_q;
        neg_d   = neg_q;
        res1_d  = res1_q;
        res2_d  = res2_q;
`ifdef MCYCLE_DIV_EN
        is_div_d  = is_div_q;
        neg_rem_d = neg_rem_q;
        op1_d     = op1_q;
`endif

        unique case (state_q)
            StIdle: begin
                if (Start) begin
                    acc_d   = {{DataWidth{1'b0}}, magnitude(Operand1, is_signed)};
                    mag2_d  = magnitude(Operand2, is_signed);
                    neg_d   = sign1 ^ sign2;
                    count_d = '0;
`ifdef MCYCLE_DIV_EN
                    is_div_d  = MCycleOp[OpDivBit];
                    neg_rem_d = sign1;
                    op1_d     = Operand1;
                    state_d   = StComputing;
`else
                    if (MCycleOp[OpDivBit]) begin
                        state_d = StDone;
                        res1_d  = '0;
                        res2_d  = '0;
                    end else begin
                        state_d = StComputing;
                    end
`endif
                end
            end
            StComputing: begin
                acc_d   = step_acc;
                count_d = count_q + 1'b1;
                if (count_q == LastCount) begin
                    state_d = StDone;
                    res1_d  = fin1;
                    res2_d  = fin2;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q <= StIdle;
            count_q <= '0;
            acc_q   <= '0;
            mag2_q  <= '0;
            neg_q   <= 1'b0;
            res1_q  <= '0;
            res2_q  <= '0;
`ifdef MCYCLE_DIV_EN
            is_div_q  <= 1'b0;
            neg_rem_q <= 1'b0;
            op1_q     <= '0;
`endif
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            acc_q   <= acc_d;
            mag2_q  <= mag2_d;
            neg_q   <= neg_d;
            res1_q  <= res1_d;
            res2_q  <= res2_d;
`ifdef MCYCLE_DIV_EN
            is_div_q  <= is_div_d;
            neg_rem_q <= neg_rem_d;
            op1_q     <= op1_d;
`endif
        end
    end

    assign Busy    = ~RESET & (((state_q == StIdle) & Start) | (state_q == StComputing));
    assign Result1 = res1_q;
    assign Result2 = res2_q;

endmodule

// File: tb/tb_mcycle_unit.sv
// ----------------------------------------------------------------------------
// tb_mcycle_unit
// Self-checking bench for mcycle_unit: directed corner cases plus randomized
// operations compared against an arithmetic reference model. Expectations for
// divide follow MCYCLE_DIV_EN the same way the design does.
// ----------------------------------------------------------------------------
module tb_mcycle_unit;

    logic        CLK;
    logic        RESET;
    logic        Start;
    logic [1:0]  MCycleOp;
    logic [31:0] Operand1;
    logic [31:0] Operand2;
    logic [31:0] Result1;
    logic [31:0] Result2;
    logic        Busy;

    int          errors = 0;
    int          checks = 0;
    logic [63:0] last_res;   // {Result2, Result1} the DUT should currently hold

    mcycle_unit dut (
        .CLK      (CLK),
        .RESET    (RESET),
        .Start    (Start),
        .MCycleOp (MCycleOp),
        .Operand1 (Operand1),
        .Operand2 (Operand2),
        .Result1  (Result1),
        .Result2  (Result2),
        .Busy     (Busy)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference result {Result2, Result1} straight from the arithmetic rules.
    function automatic logic [63:0] model(input logic [1:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
        longint      sa;
        longint      sb;
        longint      q;
        longint      r;
        logic [63:0] res;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        if (!op[0]) begin
            if (op[1]) res = {32'd0, a} * {32'd0, b};
            else       res = sa * sb;
            return res;
        end
`ifdef MCYCLE_DIV_EN
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        if (op[1]) return {a % b, a / b};
        q = sa / sb;
        r = sa % sb;
        res = {r[31:0], q[31:0]};
        return res;
`else
        return 64'd0;
`endif
    endfunction

    function automatic int exp_latency(input logic [1:0] op);
`ifdef MCYCLE_DIV_EN
        return 33;
`else
        return op[0] ? 1 : 33;
`endif
    endfunction

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 5))
            0:       return 32'd0;
            1:       return 32'd1;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'h8000_0000;
            4:       return 32'($urandom_range(0, 15));
            default: return 32'($urandom);
        endcase
    endfunction

    // Called inside an IDLE cycle before its rising edge; that cycle is cycle 0.
    task automatic run_op(input string tag, input logic [1:0] op, input logic [31:0] a,
                          input logic [31:0] b);
        logic [63:0] exp;
        int          lat;
        exp      = model(op, a, b);
        Start    = 1'b1;
        MCycleOp = op;
        Operand1 = a;
        Operand2 = b;
        #1;
        check_eq({tag, "_busy_c0"}, 64'(Busy), 64'd1);
        lat = 0;
        do begin
            @(posedge CLK);
            #1;
            // Scramble inputs after latching; they must not matter.
            Start    = 1'b0;
            Operand1 = $urandom;
            Operand2 = $urandom;
            MCycleOp = 2'($urandom);
            #1;
            lat++;
            if (lat == 10) check_eq({tag, "_hold_mid"}, {Result2, Result1}, last_res);
        end while (Busy && lat < 40);
        check_eq({tag, "_latency"}, 64'(lat), 64'(exp_latency(op)));
        check_eq({tag, "_result"}, {Result2, Result1}, exp);
        last_res = exp;
        @(posedge CLK);
        #2;
        check_eq({tag, "_idle_busy"}, 64'(Busy), 64'd0);
        check_eq({tag, "_idle_hold"}, {Result2, Result1}, last_res);
    endtask

    initial begin
        int bad;
        logic expb;
        RESET    = 1'b1;
        Start    = 1'b1;
        MCycleOp = 2'b00;
        Operand1 = 32'h1234_5678;
        Operand2 = 32'h9ABC_DEF0;
        last_res = 64'd0;

        // Reset: Busy low despite Start, results cleared.
        @(posedge CLK);
        #2;
        check_eq("reset_busy", 64'(Busy), 64'd0);
        @(posedge CLK);
        #2;
        check_eq("reset_results", {Result2, Result1}, 64'd0);
        RESET = 1'b0;
        Start = 1'b0;

        // First cycle after reset release accepts Start.
        run_op("smul_neg", 2'b00, 32'hFFFF_FFFE, 32'h0000_0003);
        run_op("umul_max", 2'b10, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        run_op("sdiv_neg", 2'b01, 32'hFFFF_FFF9, 32'h0000_0002);
        run_op("udiv_zero", 2'b11, 32'h0000_0064, 32'h0000_0000);
        run_op("sdiv_ovf", 2'b01, 32'h8000_0000, 32'hFFFF_FFFF);
        run_op("sdiv_zero", 2'b01, 32'hFFFF_FFF9, 32'h0000_0000);
        run_op("sdiv_pos_neg", 2'b01, 32'h0000_0007, 32'hFFFF_FFFE);
        run_op("smul_min", 2'b00, 32'h8000_0000, 32'h8000_0000);

        // Reset in cycle 10 of a multiply.
        Start    = 1'b1;
        MCycleOp = 2'b00;
        Operand1 = $urandom;
        Operand2 = $urandom;
        for (int c = 1; c <= 10; c++) begin
            @(posedge CLK);
            #1;
            Start = 1'b0;
        end
        RESET = 1'b1;
        #1;
        check_eq("midop_reset_busy", 64'(Busy), 64'd0);
        @(posedge CLK);
        #1;
        RESET = 1'b0;
        #1;
        check_eq("post_reset_busy", 64'(Busy), 64'd0);
        check_eq("post_reset_results", {Result2, Result1}, 64'd0);
        last_res = 64'd0;
        run_op("after_reset_smul", 2'b00, 32'hFFFF_FF85, 32'h0000_1234);

        // Start held high: back-to-back 5 x 7 unsigned multiplies.
        bad      = 0;
        Start    = 1'b1;
        MCycleOp = 2'b10;
        Operand1 = 32'd5;
        Operand2 = 32'd7;
        #1;
        for (int c = 0; c <= 67; c++) begin
            if (c > 0) begin
                @(posedge CLK);
                #2;
            end
            expb = (c == 33 || c == 67) ? 1'b0 : 1'b1;
            if (Busy !== expb) bad++;
            if (c == 33) check_eq("hold_start_first", 64'(Result1), 64'h23);
            if (c == 67) begin
                check_eq("hold_start_second", {Result2, Result1}, 64'h23);
                Start = 1'b0;
            end
        end
        check_eq("hold_start_busy_pattern", 64'(bad), 64'd0);
        last_res = 64'h23;
        @(posedge CLK);
        #2;
        check_eq("hold_start_stop", 64'(Busy), 64'd0);

        // Randomized operations.
        for (int i = 0; i < 24; i++) begin
            run_op($sformatf("rand%0d", i), 2'($urandom), pick_operand(), pick_operand());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
